// File: rtl/kernel_cc_min_label_reduce_pkg.sv
// Shared types and constants for the connected-components label-reduce stage.
package kernel_cc_pkg;

  localparam int CC_DATA_WIDTH = 32;
  localparam int CC_DEG_W      = 16;
  localparam logic [CC_DATA_WIDTH-1:0] CC_LABEL_MAX = '1;

  typedef enum logic [1:0] {
    S_HDR,
    S_OWN,
    S_NBR,
    S_OUT
  } cc_state_e;

endpackage

// File: rtl/kernel_cc_min_label_reduce_if.sv
// Upstream FIFO pop port and downstream FIFO push port of the label-reduce stage.
interface kernel_cc_min_label_reduce_if #(
  parameter int DATA_WIDTH = kernel_cc_pkg::CC_DATA_WIDTH
);
  logic                  in_empty_n;
  logic                  in_read;
  logic [DATA_WIDTH-1:0] in_dout;
  logic                  out_full_n;
  logic                  out_write;
  logic [DATA_WIDTH-1:0] out_din;

  modport slave (
    input  in_empty_n, in_dout, out_full_n,
    output in_read, out_write, out_din
  );

  modport master (
    output in_empty_n, in_dout, out_full_n,
    input  in_read, out_write, out_din
  );
endinterface

// File: rtl/kernel_cc_sat_counter.sv
// Saturating up-counter with asynchronous active-low clear; holds at all-ones.
module kernel_cc_sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             inc,
  output logic [WIDTH-1:0] cnt
);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc && (cnt_q != {WIDTH{1'b1}})) cnt_d = cnt_q + {{(WIDTH-1){1'b0}}, 1'b1};
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/kernel_cc_min_label_reduce.sv
// Pops header/own/DEG neighbour labels per vertex and pushes min(own, neighbours).
// Optional changed-vertex counter under macro KERNEL_CC_MINRED_STATS_EN.
module kernel_cc_min_label_reduce
  import kernel_cc_pkg::*;
#(
  parameter int DATA_WIDTH = CC_DATA_WIDTH,
  parameter int DEG_W      = CC_DEG_W
) (
  input  logic                       clk,
  input  logic                       reset_n,
  kernel_cc_min_label_reduce_if.slave strm,
  output logic                       busy,
  output logic [31:0]                changed_cnt
);

  cc_state_e             state_q, state_d;
  logic [DEG_W-1:0]      deg_q, deg_d;
  logic [DATA_WIDTH-1:0] own_q, own_d;
  logic [DATA_WIDTH-1:0] min_q, min_d;
  logic                  rd_en;
  logic                  wr_en;
  logic                  word_avail;

  // reset_n gates the pop so nothing is consumed while reset is held
  assign word_avail = reset_n & strm.in_empty_n;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_HDR;
      deg_q   <= '0;
      own_q   <= '0;
      min_q   <= '0;
    end else begin
      state_q <= state_d;
      deg_q   <= deg_d;
      own_q   <= own_d;
      min_q   <= min_d;
    end
  end

  always_comb begin
    state_d = state_q;
    deg_d   = deg_q;
    own_d   = own_q;
    min_d   = min_q;
    rd_en   = 1'b0;
    wr_en   = 1'b0;
    case (state_q)
      S_HDR: begin
        rd_en = word_avail;
        if (word_avail) begin
          deg_d   = strm.in_dout[DEG_W-1:0];
          state_d = S_OWN;
        end
      end
      S_OWN: begin
        rd_en = word_avail;
        if (word_avail) begin
          own_d   = strm.in_dout;
          min_d   = strm.in_dout;
          state_d = (deg_q != '0) ? S_NBR : S_OUT;
        end
      end
      S_NBR: begin
        rd_en = word_avail;
        if (word_avail) begin
          min_d = (strm.in_dout < min_q) ? strm.in_dout : min_q;
          deg_d = deg_q - {{(DEG_W-1){1'b0}}, 1'b1};
          if (deg_q == {{(DEG_W-1){1'b0}}, 1'b1}) state_d = S_OUT;
        end
      end
      S_OUT: begin
        wr_en = strm.out_full_n;
        if (strm.out_full_n) state_d = S_HDR;
      end
      default: state_d = S_HDR;
    endcase
  end

  assign strm.in_read   = rd_en;
  assign strm.out_write = wr_en;
  assign strm.out_din   = min_q;
  assign busy           = (state_q != S_HDR);

`ifdef KERNEL_CC_MINRED_STATS_EN
  logic changed;
  assign changed = wr_en & (min_q < own_q);

  kernel_cc_sat_counter #(
    .WIDTH(32)
  ) u_changed_cnt (
    .clk  (clk),
    .clr_n(reset_n),
    .inc  (changed),
    .cnt  (changed_cnt)
  );
`else
  assign changed_cnt = '0;
`endif

endmodule

// File: tb/tb_kernel_cc_min_label_reduce.sv
// Directed bench for kernel_cc_min_label_reduce with a queue-modelled upstream FIFO.
module tb_kernel_cc_min_label_reduce;
  import kernel_cc_pkg::*;

`ifdef KERNEL_CC_MINRED_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic        busy;
  logic [31:0] changed_cnt;

  kernel_cc_min_label_reduce_if #(.DATA_WIDTH(32)) ifc ();

  kernel_cc_min_label_reduce #(
    .DATA_WIDTH(32),
    .DEG_W     (16)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .strm       (ifc),
    .busy       (busy),
    .changed_cnt(changed_cnt)
  );

  always #5 clk = ~clk;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] in_q[$];
  int          n_out   = 0;
  logic [31:0] last_out;
  int          last_cyc;
  int          cyc_n   = 0;
  bit          stall_rand = 1'b0;
  bit          viol = 1'b0;
  bit          s_rd, s_wr;
  logic [31:0] s_din;
  logic [31:0] exp_chg = 32'h0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic drive_in();
    ifc.in_empty_n = (in_q.size() != 0) && !(stall_rand && ($urandom_range(0, 1) == 0));
    ifc.in_dout    = (in_q.size() != 0) ? in_q[0] : 32'h0;
  endtask

  // One clock: sample on the falling edge, apply the FIFO effects just after the rising edge.
  task automatic cyc();
    @(negedge clk);
    s_rd  = ifc.in_read;
    s_wr  = ifc.out_write;
    s_din = ifc.out_din;
    if (s_rd && !ifc.in_empty_n) viol = 1'b1;
    if (s_wr && !ifc.out_full_n) viol = 1'b1;
    @(posedge clk);
    #1;
    cyc_n++;
    if (s_rd) void'(in_q.pop_front());
    if (s_wr) begin
      n_out++;
      last_out = s_din;
      last_cyc = cyc_n;
    end
    drive_in();
  endtask

  task automatic run_group(input string tag, input logic [31:0] hdr, input logic [31:0] own,
                           input logic [31:0] nbrs[$], input int exp_lat);
    logic [31:0] m;
    int n0, c0, budget;
    m = own;
    foreach (nbrs[i]) if (nbrs[i] < m) m = nbrs[i];
    in_q.push_back(hdr);
    in_q.push_back(own);
    foreach (nbrs[i]) in_q.push_back(nbrs[i]);
    drive_in();
    n0 = n_out;
    c0 = cyc_n;
    budget = 4 * nbrs.size() + 100;
    while (n_out == n0 && budget > 0) begin
      cyc();
      budget--;
    end
    chk({tag, "_nout"}, n_out, n0 + 1);
    chk({tag, "_min"}, last_out, m);
    if (exp_lat > 0) chk({tag, "_lat"}, last_cyc - c0, exp_lat);
    if (m < own && exp_chg != 32'hFFFF_FFFF) exp_chg++;
    chk({tag, "_chg"}, changed_cnt, STATS ? exp_chg : 32'h0);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] nb[$];
    int n0, qsz, budget;

    // reset state with upstream data present
    reset_n        = 1'b0;
    ifc.in_empty_n = 1'b1;
    ifc.in_dout    = 32'h3;
    ifc.out_full_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rd", ifc.in_read, 0);
    chk("rst_wr", ifc.out_write, 0);
    chk("rst_din", ifc.out_din, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cnt", changed_cnt, 0);
    drive_in();
    reset_n = 1'b1;
    cyc();

    // basic group and deg=0
    nb.delete(); nb.push_back(32'd7); nb.push_back(32'd12); nb.push_back(32'd4);
    run_group("t1", 32'd3, 32'd9, nb, 6);
    nb.delete();
    run_group("t2", 32'd0, 32'd5, nb, 3);

    // all-ones labels, ignored upper header bits, equal neighbour
    nb.delete(); nb.push_back(32'hFFFF_FFFF); nb.push_back(32'd10);
    run_group("ones", 32'd2, 32'hFFFF_FFFF, nb, 5);
    nb.delete(); nb.push_back(32'd20);
    run_group("hibits", 32'hABCD_0001, 32'd20, nb, 4);
    nb.delete();
    run_group("ownmax", 32'd0, CC_LABEL_MAX, nb, 3);

    // upstream randomly empty
    stall_rand = 1'b1;
    nb.delete(); nb.push_back(32'd8); nb.push_back(32'd8);
    run_group("stall_a", 32'd2, 32'd8, nb, 0);
    nb.delete(); nb.push_back(32'd6);
    run_group("stall_b", 32'd1, 32'd2, nb, 0);
    stall_rand = 1'b0;
    chk("rd_while_empty", viol, 0);

    // downstream full while in S_OUT
    in_q.push_back(32'd1); in_q.push_back(32'd10); in_q.push_back(32'd3);
    in_q.push_back(32'd0); in_q.push_back(32'd7);
    ifc.out_full_n = 1'b0;
    drive_in();
    repeat (3) cyc();
    qsz = in_q.size();
    for (int i = 0; i < 10; i++) begin
      cyc();
      chk("ofull_wr", s_wr, 0);
      chk("ofull_din", s_din, 32'd3);
      chk("ofull_rd", s_rd, 0);
    end
    chk("ofull_nopop", in_q.size(), qsz);
    ifc.out_full_n = 1'b1;
    n0 = n_out;
    cyc();
    chk("ofull_wr_now", n_out, n0 + 1);
    chk("ofull_val", last_out, 32'd3);
    if (exp_chg != 32'hFFFF_FFFF) exp_chg++;
    n0 = n_out;
    budget = 20;
    while (n_out == n0 && budget > 0) begin
      cyc();
      budget--;
    end
    chk("ofull_next", last_out, 32'd7);
    chk("ofull_chg", changed_cnt, STATS ? exp_chg : 32'h0);

    // reset in the middle of a deg=4 group
    in_q.push_back(32'd4); in_q.push_back(32'd50); in_q.push_back(32'd40);
    in_q.push_back(32'd30); in_q.push_back(32'd20); in_q.push_back(32'd10);
    drive_in();
    repeat (3) cyc();
    n0 = n_out;
    reset_n = 1'b0;
    #1;
    chk("mrst_rd", ifc.in_read, 0);
    chk("mrst_wr", ifc.out_write, 0);
    chk("mrst_din", ifc.out_din, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_cnt", changed_cnt, 0);
    exp_chg = 32'h0;
    in_q.delete();
    drive_in();
    cyc();
    reset_n = 1'b1;
    chk("mrst_drop", n_out, n0);
    nb.delete(); nb.push_back(32'd25); nb.push_back(32'd40); nb.push_back(32'd27);
    run_group("post_rst", 32'd3, 32'd30, nb, 6);

    // maximum degree
    nb.delete();
    for (int i = 0; i < 65535; i++) nb.push_back((i == 40000) ? 32'h0000_1234 : 32'hFFFF_FFFF);
    run_group("maxdeg", 32'h0000_FFFF, 32'h0010_0000, nb, 65538);
    nb.delete();

`ifdef KERNEL_CC_MINRED_STATS_EN
    force dut.u_changed_cnt.cnt_q = 32'hFFFF_FFFE;
    cyc();
    release dut.u_changed_cnt.cnt_q;
    exp_chg = 32'hFFFF_FFFE;
    chk("preload", changed_cnt, exp_chg);
    nb.delete(); nb.push_back(32'd3);
    run_group("sat_a", 32'd1, 32'd9, nb, 4);
    nb.delete(); nb.push_back(32'd4);
    run_group("sat_b", 32'd1, 32'd20, nb, 4);
    nb.delete(); nb.push_back(32'd50); nb.push_back(32'd60);
    run_group("sat_c", 32'd2, 32'd100, nb, 5);
    chk("sat_hold", changed_cnt, 32'hFFFF_FFFF);
`else
    nb.delete(); nb.push_back(32'd1);
    run_group("nostats", 32'd1, 32'd9, nb, 4);
    chk("nostats_cnt", changed_cnt, 32'h0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
